// File: rtl/universal_shift_reg_if.sv
// Control/data bundle for universal_shift_reg.
// master drives operations; slave returns the registered word and status.
interface universal_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic [CW-1:0]    cnt;
    logic             full;

    modport master (
        output en, mode, d, sin_l, sin_r,
        input  q, sout_l, sout_r, cnt, full
    );

    modport slave (
        input  en, mode, d, sin_l, sin_r,
        output q, sout_l, sout_r, cnt, full
    );
endinterface

// File: rtl/universal_shift_reg.sv
// Multi-mode WIDTH-bit register: load, shifts, rotates, ASR, clear.
// Saturating shift counter flags a fully deserialised word.
module universal_shift_reg #(
    parameter int          WIDTH     = 8,
    parameter logic [63:0] RESET_VAL = '0
) (
    input logic                  clk,
    input logic                  rst,
    universal_shift_reg_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    typedef enum logic [2:0] {
        HOLD, LOAD, SHL, SHR, ROL, ROR, ASR, CLR
    } mode_t;

    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_inc;

    // Saturate rather than wrap so full stays asserted.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q   <= RESET_VAL[WIDTH-1:0];
            cnt <= '0;
        end else if (bus.en) begin
            case (mode_t'(bus.mode))
                LOAD: begin
                    q   <= bus.d;
                    cnt <= '0;
                end
                SHL: begin
                    q   <= {q[WIDTH-2:0], bus.sin_l};
                    cnt <= cnt_inc;
                end
                SHR: begin
                    q   <= {bus.sin_r, q[WIDTH-1:1]};
                    cnt <= cnt_inc;
                end
                ROL: begin
                    q   <= {q[WIDTH-2:0], q[WIDTH-1]};
                    cnt <= cnt_inc;
                end
                ROR: begin
                    q   <= {q[0], q[WIDTH-1:1]};
                    cnt <= cnt_inc;
                end
                ASR: begin
                    q   <= {q[WIDTH-1], q[WIDTH-1:1]};
                    cnt <= cnt_inc;
                end
                CLR: begin
                    q   <= '0;
                    cnt <= '0;
                end
                default: begin
                    q   <= q;
                    cnt <= cnt;
                end
            endcase
        end
    end

    assign bus.q      = q;
    assign bus.cnt    = cnt;
    assign bus.sout_l = q[WIDTH-1];
    assign bus.sout_r = q[0];
    assign bus.full   = (cnt == CNT_MAX);
endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg at widths 8, 2 and 33.
module tb_universal_shift_reg;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    universal_shift_reg_if #(.WIDTH(8))  bus8 ();
    universal_shift_reg_if #(.WIDTH(2))  bus2 ();
    universal_shift_reg_if #(.WIDTH(33)) bus33 ();

    universal_shift_reg #(.WIDTH(8), .RESET_VAL(64'hA5)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8)
    );
    universal_shift_reg #(.WIDTH(2), .RESET_VAL(64'h0)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );
    universal_shift_reg #(.WIDTH(33), .RESET_VAL(64'h0)) dut33 (
        .clk(clk), .rst(rst), .bus(bus33)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input logic [2:0] m, input logic [7:0] dv,
                       input logic sl, input logic sr);
        bus8.en    = 1'b1;
        bus8.mode  = m;
        bus8.d     = dv;
        bus8.sin_l = sl;
        bus8.sin_r = sr;
        step();
    endtask

    logic [7:0]  pat;
    logic [1:0]  e2;
    logic [32:0] e33;
    logic        prev1;

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        bus8.en = 1'b0;  bus8.mode = 3'd0;  bus8.d = '0;
        bus8.sin_l = 1'b0;  bus8.sin_r = 1'b0;
        bus2.en = 1'b0;  bus2.mode = 3'd0;  bus2.d = '0;
        bus2.sin_l = 1'b0;  bus2.sin_r = 1'b0;
        bus33.en = 1'b0; bus33.mode = 3'd0; bus33.d = '0;
        bus33.sin_l = 1'b0; bus33.sin_r = 1'b0;

        // 1: reset and load
        #12;
        check("rst_q", 64'(bus8.q), 64'hA5);
        check("rst_cnt", 64'(bus8.cnt), 64'd0);
        check("rst_full", 64'(bus8.full), 64'd0);
        rst = 1'b1;
        step();
        check("rel_hold_q", 64'(bus8.q), 64'hA5);
        op8(3'd1, 8'h3C, 1'b0, 1'b0);
        check("load_q", 64'(bus8.q), 64'h3C);
        check("load_cnt", 64'(bus8.cnt), 64'd0);
        check("load_full", 64'(bus8.full), 64'd0);

        // 2: deserialise and saturate
        op8(3'd7, 8'hFF, 1'b0, 1'b0);
        check("clr_q", 64'(bus8.q), 64'h00);
        pat = 8'b1011_0010;
        for (int i = 7; i >= 0; i--) begin
            op8(3'd2, 8'h00, pat[i], 1'b0);
        end
        check("deser_q", 64'(bus8.q), 64'hB2);
        check("deser_cnt", 64'(bus8.cnt), 64'd8);
        check("deser_full", 64'(bus8.full), 64'd1);
        check("deser_soutl", 64'(bus8.sout_l), 64'd1);
        op8(3'd2, 8'h00, 1'b1, 1'b0);
        check("sat_q", 64'(bus8.q), 64'h65);
        check("sat_cnt", 64'(bus8.cnt), 64'd8);
        check("sat_full", 64'(bus8.full), 64'd1);

        // 3: rotates and ASR; serial inputs are X and must not leak
        op8(3'd1, 8'h81, 1'b0, 1'b0);
        op8(3'd4, 8'hxx, 1'bx, 1'bx);
        check("rol_q", 64'(bus8.q), 64'h03);
        check("rol_cnt", 64'(bus8.cnt), 64'd1);
        op8(3'd5, 8'hxx, 1'bx, 1'bx);
        op8(3'd5, 8'hxx, 1'bx, 1'bx);
        check("ror2_q", 64'(bus8.q), 64'hC0);
        op8(3'd1, 8'h90, 1'b0, 1'b0);
        op8(3'd6, 8'hxx, 1'bx, 1'bx);
        check("asr_q", 64'(bus8.q), 64'hC8);
        check("asr_soutr", 64'(bus8.sout_r), 64'd0);

        // 4: enable gating
        op8(3'd1, 8'h0F, 1'b0, 1'b0);
        bus8.en = 1'b0;
        bus8.d  = 8'hAA;
        bus8.sin_l = 1'b1;
        bus8.sin_r = 1'b1;
        bus8.mode = 3'd2; step();
        check("en0_shl_q", 64'(bus8.q), 64'h0F);
        bus8.mode = 3'd3; step();
        check("en0_shr_q", 64'(bus8.q), 64'h0F);
        bus8.mode = 3'd7; step();
        check("en0_clr_q", 64'(bus8.q), 64'h0F);
        check("en0_cnt", 64'(bus8.cnt), 64'd0);

        // 5: async reset mid-sequence
        for (int i = 0; i < 4; i++) begin
            op8(3'd3, 8'h00, 1'b0, 1'b1);
        end
        check("shr4_q", 64'(bus8.q), 64'hF0);
        check("shr4_cnt", 64'(bus8.cnt), 64'd4);
        #2 rst = 1'b0;
        #1;
        check("arst_q", 64'(bus8.q), 64'hA5);
        check("arst_cnt", 64'(bus8.cnt), 64'd0);
        #1 rst = 1'b1;
        op8(3'd3, 8'h00, 1'b0, 1'b1);
        check("post_rst_q", 64'(bus8.q), 64'hD2);
        check("post_rst_cnt", 64'(bus8.cnt), 64'd1);
        bus8.en = 1'b0;

        // 6: width sweep, WIDTH = 2
        bus2.en = 1'b1; bus2.mode = 3'd1; bus2.d = 2'b11;
        step();
        check("w2_load", 64'(bus2.q), 64'h3);
        e2 = 2'b11;
        bus2.mode = 3'd3; bus2.sin_r = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prev1 = e2[1];
            e2 = e2 >> 1;
            step();
            check("w2_q", 64'(bus2.q), 64'(e2));
            check("w2_soutr", 64'(bus2.sout_r), 64'(prev1));
        end
        check("w2_full", 64'(bus2.full), 64'd1);
        check("w2_cnt", 64'(bus2.cnt), 64'd2);
        bus2.en = 1'b0;

        // WIDTH = 33
        bus33.en = 1'b1; bus33.mode = 3'd1;
        bus33.d = 33'h1_A5C3_0F69;
        step();
        check("w33_load", 64'(bus33.q), 64'h1_A5C3_0F69);
        e33 = 33'h1_A5C3_0F69;
        bus33.mode = 3'd3; bus33.sin_r = 1'b0;
        for (int i = 0; i < 33; i++) begin
            prev1 = e33[1];
            e33 = e33 >> 1;
            step();
            check("w33_q", 64'(bus33.q), 64'(e33));
            check("w33_soutr", 64'(bus33.sout_r), 64'(prev1));
        end
        check("w33_zero", 64'(bus33.q), 64'd0);
        check("w33_full", 64'(bus33.full), 64'd1);
        check("w33_cnt", 64'(bus33.cnt), 64'd33);
        bus33.en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised, edge-triggered multi-mode register: the next generation of the single-bit master-slave D flip-flop.
- Holds a WIDTH-bit word with the following operations:
  - parallel load
  - logical shift left and right with serial inputs
  - rotate left and right
  - arithmetic shift right
  - synchronous clear
- Includes a shift counter with a full flag for serial-to-parallel deserialisation.
- Sits on serial front ends and general datapath staging.

Parameters:
WIDTH, 8, register width in bits; legal range 2..64.
RESET_VAL, 0, value loaded into q on reset; WIDTH bits, truncated if wider.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-low; asserting (0) immediately forces reset values.
en  input  1  operation enable; 0 means hold everything, regardless of mode.
mode  input  3  operation select (encoding below).
d  input  WIDTH  parallel load data.
sin_l  input  1  serial in for left shift; enters bit 0.
sin_r  input  1  serial in for logical right shift; enters bit WIDTH-1.
q  output  WIDTH  registered word.
sout_l  output  1  q[WIDTH-1], combinational from q.
sout_r  output  1  q[0], combinational from q.
cnt  output  clog2(WIDTH+1)  shifts since the last load or clear, saturating.
full  output  1  high when cnt == WIDTH, decoded from registered cnt.

Behaviour:
Reset:
- While rst = 0: q = RESET_VAL and cnt = 0, asynchronously; this also gives full = 0.
- rst deasserting has no effect until the next rising edge.
- Reset in the middle of a shift sequence discards the partial word and the count.

Mode encoding, applied at the rising edge when en = 1:
- 0 HOLD: q and cnt unchanged.
- 1 LOAD: q <= d; cnt <= 0.
- 2 SHL: q <= {q[WIDTH-2:0], sin_l}; cnt increments.
- 3 SHR: q <= {sin_r, q[WIDTH-1:1]}; cnt increments.
- 4 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; cnt increments.
- 5 ROR: q <= {q[0], q[WIDTH-1:1]}; cnt increments.
- 6 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}, sign-preserving; cnt increments.
- 7 CLR: q <= 0 (not RESET_VAL); cnt <= 0.

Enable:
- en = 0: q and cnt hold; mode, d and the serial inputs are ignored.

Counter:
- cnt increments by 1 per enabled shift or rotate cycle.
- cnt saturates at WIDTH; further shifts still update q but leave cnt = WIDTH.
- No wrap-around.

Timing:
- Latency: q reflects the operation one clock after the sampling edge.
- sout_l, sout_r and full are valid in the same cycle as the q (or cnt) they decode.

Rotates:
- The serial inputs are ignored in ROL and ROR.
- After WIDTH rotates, q equals its starting value.

Inputs in flight:
- An X on d or on a serial input must only propagate into q in the modes that use that input.

Implementation constraints:
- Single always block sensitive to posedge clk and negedge rst.
- No latches, no gated clocks.

Test Plan:
1. Reset and load:
   - Stimulus: RESET_VAL = 8'hA5; hold rst = 0, then release; next edge en = 1, mode = 1, d = 8'h3C.
   - Required: q = 8'hA5 during reset; after the edge q = 8'h3C, cnt = 0, full = 0.
2. Deserialise and saturate:
   - Stimulus: after CLR, apply 8 SHL cycles with sin_l = 1,0,1,1,0,0,1,0.
   - Required: q = 8'hB2, cnt = 8, full = 1.
   - Stimulus: a 9th SHL with sin_l = 1.
   - Required: q = 8'h65, cnt stays 8.
3. Rotate and arithmetic shift:
   - Stimulus: load 8'h81; ROL.
   - Required: q = 8'h03.
   - Stimulus: ROR twice.
   - Required: q = 8'hC0.
   - Stimulus: load 8'h90; ASR.
   - Required: q = 8'hC8, sout_r = 0.
4. Enable gating:
   - Stimulus: load 8'h0F; set en = 0 and apply mode = 2, 3, 7 over 3 edges.
   - Required: q stays 8'h0F and cnt stays 0 throughout.
5. Asynchronous reset mid-sequence:
   - Stimulus: after 4 SHR cycles with sin_r = 1, assert rst between clock edges.
   - Required: q = RESET_VAL and cnt = 0 before the next edge.
   - Required after release: the next SHR yields cnt = 1.
6. Width sweep:
   - Stimulus: WIDTH = 2 and WIDTH = 33; load, then WIDTH SHR cycles with sin_r = 0.
   - Required: q = 0, full = 1, sout_r equals the previous q[1] on every cycle.
